// File: rtl/aes256_key_sched_ctrl.sv
// AES-256 key-schedule sequencer: steps the external single-round expander
// through rounds 0..14, captures each round key, and serves them back to the
// cipher core in forward (encrypt) or reversed (decrypt) order.
module aes256_key_sched_ctrl #(
  parameter int unsigned KEY_WIDTH   = 256,
  parameter int unsigned NUM_RK      = 15,
  parameter int unsigned STEP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [KEY_WIDTH-1:0] key_i,
  input  logic                 dec_i,
  output logic                 busy_o,
  output logic                 ready_o,
  output logic                 done_o,
  output logic [KEY_WIDTH-1:0] ke_key_o,
  output logic [3:0]           ke_round_o,
  output logic                 ke_inv_en_o,
  input  logic [127:0]         ke_round_key_i,
  input  logic                 rk_req_i,
  input  logic [3:0]           rk_idx_i,
  output logic                 rk_valid_o,
  output logic [127:0]         rk_o,
  output logic                 rk_err_o
);

  localparam int unsigned   SW      = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [3:0]    LAST_RK = 4'(NUM_RK - 1);
  localparam logic [SW-1:0] LAST_S  = SW'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_READY
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [KEY_WIDTH-1:0] r_key;
  logic                 r_dec;
  logic [3:0]           r_round;
  logic [SW-1:0]        r_step;
  logic                 r_done;
  logic [127:0]         r_store [NUM_RK];
  logic                 r_rk_valid;
  logic [127:0]         r_rk;
  logic                 r_rk_err;

  logic                 w_start_ok;
  logic                 w_capture;
  logic                 w_last_cap;
  logic [3:0]           w_eidx;
  logic                 w_rd_err;

  assign w_start_ok = start_i && (r_state != ST_EXPAND);
  assign w_capture  = (r_state == ST_EXPAND) && (r_step == LAST_S);
  assign w_last_cap = w_capture && (r_round == LAST_RK);
  assign w_eidx     = r_dec ? (LAST_RK - rk_idx_i) : rk_idx_i;
  assign w_rd_err   = (r_state != ST_READY) || (rk_idx_i > LAST_RK);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (start_i)    w_next = ST_EXPAND;
      ST_EXPAND: if (w_last_cap) w_next = ST_READY;
      ST_READY:  if (start_i)    w_next = ST_EXPAND;
      default:                   w_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    busy_o     = 1'b0;
    ready_o    = 1'b0;
    ke_round_o = '0;
    case (r_state)
      ST_EXPAND: begin
        busy_o     = 1'b1;
        ke_round_o = r_round;
      end
      ST_READY:  ready_o = 1'b1;
      default:   ;
    endcase
  end

  // Key/order latch plus round and step counters; done marks the EXPAND->READY edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key   <= '0;
      r_dec   <= 1'b0;
      r_round <= '0;
      r_step  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last_cap;
      if (w_start_ok) begin
        r_key   <= key_i;
        r_dec   <= dec_i;
        r_round <= '0;
        r_step  <= '0;
      end else if (r_state == ST_EXPAND) begin
        if (r_step == LAST_S) begin
          r_step  <= '0;
          r_round <= (r_round == LAST_RK) ? '0 : r_round + 4'd1;
        end else begin
          r_step <= r_step + 1'b1;
        end
      end
    end
  end

  // Round-key store; contents are guarded by ready_o rather than reset
  always_ff @(posedge clk) begin
    if (w_capture) r_store[r_round] <= ke_round_key_i;
  end

  // Read port: one-cycle latency, data and error held between requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rk_valid <= 1'b0;
      r_rk       <= '0;
      r_rk_err   <= 1'b0;
    end else begin
      r_rk_valid <= rk_req_i;
      if (rk_req_i) begin
        if (w_rd_err) begin
          r_rk     <= '0;
          r_rk_err <= 1'b1;
        end else begin
          r_rk     <= r_store[w_eidx];
          r_rk_err <= 1'b0;
        end
      end
    end
  end

  assign done_o      = r_done;
  assign ke_key_o    = r_key;
  assign ke_inv_en_o = 1'b0;
  assign rk_valid_o  = r_rk_valid;
  assign rk_o        = r_rk;
  assign rk_err_o    = r_rk_err;

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Bench for aes256_key_sched_ctrl: a behavioural AES-256 expander feeds the
// DUT, read results are checked through an expected-value queue.
module tb_aes256_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [255:0] key_i;
  logic         dec_i;
  logic         busy_o, ready_o, done_o;
  logic [255:0] ke_key_o;
  logic [3:0]   ke_round_o;
  logic         ke_inv_en_o;
  logic [127:0] ke_round_key_i;
  logic         rk_req_i;
  logic [3:0]   rk_idx_i;
  logic         rk_valid_o;
  logic [127:0] rk_o;
  logic         rk_err_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic         err;
    logic [127:0] rk;
  } exp_t;
  exp_t         sbq[$];
  logic         prev_valid = 1'b0;
  logic [127:0] last_rk    = '0;

  typedef struct {
    logic         dec;
    logic [3:0]   idx;
    logic         err;
    logic [127:0] rk;
  } vec_t;
  vec_t tv[8];

  localparam logic [255:0] K1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  aes256_key_sched_ctrl #(.KEY_WIDTH(256), .NUM_RK(15), .STEP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .key_i(key_i), .dec_i(dec_i),
    .busy_o(busy_o), .ready_o(ready_o), .done_o(done_o),
    .ke_key_o(ke_key_o), .ke_round_o(ke_round_o), .ke_inv_en_o(ke_inv_en_o),
    .ke_round_key_i(ke_round_key_i),
    .rk_req_i(rk_req_i), .rk_idx_i(rk_idx_i),
    .rk_valid_o(rk_valid_o), .rk_o(rk_o), .rk_err_o(rk_err_o)
  );

  always #5 clk = ~clk;

  // ---------------- AES-256 key expansion reference ----------------
  function automatic logic [7:0] gm(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] t, inv;
    t = x; inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t   = gm(t, t);
      inv = gm(inv, t);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  function automatic logic [127:0] aes_rk(input logic [255:0] k, input logic [3:0] r);
    logic [31:0] w[60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          ri;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (i % 8 == 4) begin
        t = subw(t);
      end
      w[i] = w[i-8] ^ t;
    end
    ri = int'(r);
    if (ri > 14) return '0;
    return {w[4*ri], w[4*ri+1], w[4*ri+2], w[4*ri+3]};
  endfunction

  assign ke_round_key_i = aes_rk(ke_key_o, ke_round_o);

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Advance one clock, then retire any read response against the queue.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (rk_valid_o) begin
      if (sbq.size() == 0) begin
        chk("rd_unexpected", 256'(rk_valid_o), 256'(0));
      end else begin
        e = sbq.pop_front();
        chk("rd_err", 256'(rk_err_o), 256'(e.err));
        chk("rd_data", 256'(rk_o), 256'(e.rk));
        last_rk = e.rk;
      end
    end else begin
      if (sbq.size() != 0) begin
        chk("rd_missing", 256'(rk_valid_o), 256'(1));
        void'(sbq.pop_front());
      end
      if (prev_valid) chk("rd_hold", 256'(rk_o), 256'(last_rk));
    end
    prev_valid = rk_valid_o;
  endtask

  task automatic rd_req(input logic [3:0] idx, input logic err, input logic [127:0] rk);
    rk_req_i = 1'b1;
    rk_idx_i = idx;
    sbq.push_back({err, rk});
  endtask

  task automatic rd(input logic [3:0] idx, input logic err, input logic [127:0] rk);
    rd_req(idx, err, rk);
    tick();
    rk_req_i = 1'b0;
  endtask

  // Full expansion with per-cycle round/key checks; optional stray start pulses.
  task automatic expand(input logic [255:0] k, input logic d, input bit inj);
    int cyc;
    key_i = k; dec_i = d; start_i = 1'b1;
    tick();
    start_i = 1'b0; key_i = ~k; dec_i = ~d;
    cyc = 1;
    while (!ready_o && cyc < 100) begin
      chk("busy", 256'(busy_o), 256'(1));
      chk("ke_round", 256'(ke_round_o), 256'((cyc - 1) / 2));
      chk("ke_key", ke_key_o, k);
      start_i = inj && (cyc == 5 || cyc == 17);
      tick();
      cyc++;
    end
    start_i = 1'b0;
    chk("latency", 256'(cyc), 256'(31));
    chk("done", 256'(done_o), 256'(1));
    chk("busy_end", 256'(busy_o), 256'(0));
    tick();
    chk("done_pulse", 256'(done_o), 256'(0));
    chk("ready_hold", 256'(ready_o), 256'(1));
  endtask

  task automatic run_table(input logic d);
    for (int i = 0; i < 8; i++) begin
      if (tv[i].dec == d) rd(tv[i].idx, tv[i].err, tv[i].rk);
    end
  endtask

  task automatic sweep(input logic [255:0] k, input logic d);
    for (int i = 0; i < 15; i++) begin
      rd_req(4'(i), 1'b0, aes_rk(k, d ? 4'(14 - i) : 4'(i)));
      tick();
    end
    rk_req_i = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    tv[0] = '{1'b0, 4'd0,  1'b0, 128'h000102030405060708090a0b0c0d0e0f};
    tv[1] = '{1'b0, 4'd1,  1'b0, 128'h101112131415161718191a1b1c1d1e1f};
    tv[2] = '{1'b0, 4'd2,  1'b0, 128'ha573c29fa176c498a97fce93a572c09c};
    tv[3] = '{1'b0, 4'd14, 1'b0, 128'h24fc79ccbf0979e9371ac23c6d68de36};
    tv[4] = '{1'b0, 4'd15, 1'b1, 128'h0};
    tv[5] = '{1'b1, 4'd0,  1'b0, 128'h24fc79ccbf0979e9371ac23c6d68de36};
    tv[6] = '{1'b1, 4'd14, 1'b0, 128'h000102030405060708090a0b0c0d0e0f};
    tv[7] = '{1'b1, 4'd15, 1'b1, 128'h0};

    rst_n = 1'b0; start_i = 1'b0; key_i = '0; dec_i = 1'b0;
    rk_req_i = 1'b0; rk_idx_i = '0;
    #1;
    chk("rst_busy",  256'(busy_o),     256'(0));
    chk("rst_ready", 256'(ready_o),    256'(0));
    chk("rst_done",  256'(done_o),     256'(0));
    chk("rst_round", 256'(ke_round_o), 256'(0));
    chk("rst_key",   ke_key_o,         256'(0));
    chk("rst_valid", 256'(rk_valid_o), 256'(0));
    chk("rst_rk",    256'(rk_o),       256'(0));
    chk("rst_err",   256'(rk_err_o),   256'(0));
    chk("inv_en",    256'(ke_inv_en_o), 256'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Read before any schedule exists
    rd(4'd3, 1'b1, 128'h0);

    // Forward expansion and reads
    expand(K1, 1'b0, 1'b0);
    run_table(1'b0);
    sweep(K1, 1'b0);

    // Restart from READY with a simultaneous read of the old schedule
    key_i = '0; dec_i = 1'b0; start_i = 1'b1;
    rd_req(4'd1, 1'b0, 128'h101112131415161718191a1b1c1d1e1f);
    tick();
    start_i = 1'b0;
    chk("restart_ready_drop", 256'(ready_o), 256'(0));
    chk("restart_busy", 256'(busy_o), 256'(1));
    rd_req(4'd0, 1'b1, 128'h0);
    tick();
    rk_req_i = 1'b0;
    cyc = 2;
    while (!ready_o && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("restart_latency", 256'(cyc), 256'(31));
    rd(4'd2, 1'b0, 128'h62636363626363636263636362636363);
    sweep(256'h0, 1'b0);

    // Decryption order with stray start pulses during expansion
    expand(K1, 1'b1, 1'b1);
    run_table(1'b1);
    sweep(K1, 1'b1);

    // Asynchronous reset in the middle of an expansion
    key_i = K1; dec_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (9) tick();
    chk("pre_rst_busy", 256'(busy_o), 256'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy",  256'(busy_o),  256'(0));
    chk("async_rst_ready", 256'(ready_o), 256'(0));
    start_i = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    start_i = 1'b0;
    tick();
    chk("rst_start_ignored", 256'(busy_o), 256'(0));
    rd(4'd0, 1'b1, 128'h0);
    expand(K1, 1'b0, 1'b0);
    run_table(1'b0);

    tick(); tick();
    chk("queue_empty", 256'(sbq.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
